// File: rtl/multiplicador_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier.
package multiplicador_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_e;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   // A single-digit operation still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multiplicador_param_digit_product.sv
// Unsigned WIDTH x DIGIT partial-product generator.
module digit_product #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic [WIDTH-1:0]       a_i,
   input  logic [DIGIT-1:0]       d_i,
   output logic [WIDTH+DIGIT-1:0] p_o
);

   assign p_o = {{DIGIT{1'b0}}, a_i} * {{WIDTH{1'b0}}, d_i};

endmodule

// File: rtl/multiplicador_param.sv
// Digit-serial signed/unsigned multiplier with start/done handshake and busy flag.
module multiplicador_param
   import multiplicador_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   entryA,
   input  logic [WIDTH-1:0]   entryB,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int N  = num_digits(WIDTH, DIGIT);
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_digit
         $error("multiplicador_param: WIDTH must be a multiple of DIGIT");
      end
      if (WIDTH < 4) begin : g_bad_width
         $error("multiplicador_param: WIDTH must be at least 4");
      end
   endgenerate

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   magA_q, magA_d, magB_q, magB_d;
   logic               neg_q, neg_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, result_q, result_d;
   logic [CW-1:0]      i_q, i_d;
   logic               done_q, done_d, busy_q, busy_d;

   logic [WIDTH-1:0]       magB_sh;
   logic [DIGIT-1:0]       digit;
   logic [WIDTH+DIGIT-1:0] pp;
   logic [2*WIDTH-1:0]     pp_sh;

   assign magB_sh = magB_q >> (DIGIT * int'(i_q));
   assign digit   = magB_sh[DIGIT-1:0];
   assign pp_sh   = {{(WIDTH-DIGIT){1'b0}}, pp} << (DIGIT * int'(i_q));

   digit_product #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_dp (
      .a_i (magA_q),
      .d_i (digit),
      .p_o (pp)
   );

   always_comb begin
      state_d  = state_q;
      magA_d   = magA_q;
      magB_d   = magB_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      i_d      = i_q;
      result_d = result_q;
      done_d   = 1'b0;
      busy_d   = busy_q;
      // busy spans the done cycle and drops on the following edge
      if (done_q) busy_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               magA_d  = (signed_mode && entryA[WIDTH-1]) ? -entryA : entryA;
               magB_d  = (signed_mode && entryB[WIDTH-1]) ? -entryB : entryB;
               neg_d   = signed_mode & (entryA[WIDTH-1] ^ entryB[WIDTH-1]);
               acc_d   = '0;
               i_d     = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = acc_q + pp_sh;
            i_d   = i_q + 1'b1;
            if (i_q == LAST) state_d = FIN;
         end
         FIN: begin
            result_d = neg_q ? -acc_q : acc_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         magA_q   <= '0;
         magB_q   <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         i_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         magA_q   <= magA_d;
         magB_q   <= magB_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         i_q      <= i_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_multiplicador_param.sv
// Directed-vector and reference-model bench for multiplicador_param at WIDTH 8 and 16.
module tb_multiplicador_param;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] res8;

   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16;
   logic [31:0] res16;

   multiplicador_param #(.WIDTH(8), .DIGIT(4)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
      .entryA(a8), .entryB(b8), .busy(busy8), .done(done8), .result(res8));

   multiplicador_param #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(sm16),
      .entryA(a16), .entryB(b16), .busy(busy16), .done(done16), .result(res16));

   int wsel = 8;
   logic        cur_done, cur_busy;
   logic [31:0] cur_res;
   assign cur_done = (wsel == 16) ? done16 : done8;
   assign cur_busy = (wsel == 16) ? busy16 : busy8;
   assign cur_res  = (wsel == 16) ? res16 : {16'h0, res8};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input int w, input bit sm,
                                           input logic [15:0] a, input logic [15:0] b);
      longint sa, sb, p;
      logic [63:0] pm;
      sa = (w == 8) ? longint'(a[7:0]) : longint'(a);
      sb = (w == 8) ? longint'(b[7:0]) : longint'(b);
      if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
      if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
      p  = sa * sb;
      pm = p;
      return (w == 8) ? {16'h0, pm[15:0]} : pm[31:0];
   endfunction

   task automatic op(input int w, input bit sm, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp, input string nm, input bit scramble);
      int lat;
      wsel = w;
      @(negedge clk);
      if (w == 16) begin start16 = 1'b1; sm16 = sm; a16 = a;      b16 = b;      end
      else         begin start8  = 1'b1; sm8  = sm; a8  = a[7:0]; b8  = b[7:0]; end
      @(posedge clk); #1;
      start8 = 1'b0; start16 = 1'b0;
      chk({nm, "_busy"}, {31'h0, cur_busy}, 32'h1);
      if (scramble) begin
         a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'b1;
         a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'b1;
      end
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (cur_done) begin lat = k; break; end
      end
      chk({nm, "_latency"}, lat, w / 4 + 1);
      chk({nm, "_result"}, cur_res, exp);
      @(posedge clk); #1;
      chk({nm, "_idle"}, {30'h0, cur_busy, cur_done}, 32'h0);
   endtask

   typedef struct {
      int          w;
      bit          sm;
      logic [15:0] a, b;
      logic [31:0] exp;
      string       nm;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8,  1'b0, 16'd200,  16'd150,  32'h0000_7530, "u200x150"};
      vecs[1] = '{8,  1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, "u255x255"};
      vecs[2] = '{8,  1'b0, 16'd0,    16'd173,  32'h0000_0000, "u0x173"};
      vecs[3] = '{8,  1'b1, 16'h00FB, 16'h0000, 32'h0000_0000, "s-5x0"};
      vecs[4] = '{8,  1'b1, 16'h0080, 16'h0080, 32'h0000_4000, "s-128x-128"};
      vecs[5] = '{8,  1'b1, 16'h00FF, 16'h007F, 32'h0000_FF81, "s-1x127"};
      vecs[6] = '{8,  1'b0, 16'h0080, 16'h0002, 32'h0000_0100, "u128x2"};
      vecs[7] = '{16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "w16_uffff"};
      vecs[8] = '{16, 1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000, "w16_s8000x7fff"};

      repeat (3) @(posedge clk);
      #1;
      chk("rst8",  {14'h0, busy8, done8, res8}, 32'h0);
      chk("rst16", {30'h0, busy16, done16}, 32'h0);
      chk("rst16_res", res16, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int v = 0; v < 9; v++) begin
         op(vecs[v].w, vecs[v].sm, vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].nm, 1'b0);
         if (v == 0) begin
            for (int c = 0; c < 10; c++) begin
               @(posedge clk); #1;
               chk("hold_7530", {16'h0, res8}, 32'h0000_7530);
            end
         end
      end

      // start held high for six edges: accepted at edge 0 and again after done
      begin
         int nd, e1, e2;
         nd = 0; e1 = -1; e2 = -1;
         wsel = 8;
         @(negedge clk);
         start8 = 1'b1; sm8 = 1'b0; a8 = 8'd3; b8 = 8'd4;
         for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (e == 5) start8 = 1'b0;
            if (done8) begin
               nd++;
               if (nd == 1) e1 = e; else e2 = e;
               chk("held_result", {16'h0, res8}, 32'h0000_000C);
            end
         end
         chk("held_ndone", nd, 2);
         chk("held_first_done", e1, 3);
         chk("held_second_done", e2, 7);
      end

      op(8, 1'b0, 16'd3, 16'd4, 32'h0000_000C, "scramble", 1'b1);

      // reset during CALC aborts with no done pulse
      begin
         int seen;
         wsel = 8;
         @(negedge clk);
         start8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd150;
         @(posedge clk); #1;
         start8 = 1'b0;
         @(posedge clk); #1;
         reset_n = 1'b0;
         @(posedge clk); #1;
         chk("abort_state", {14'h0, busy8, done8, res8}, 32'h0);
         reset_n = 1'b1;
         seen = 0;
         for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done8) seen++;
         end
         chk("abort_no_done", seen, 0);
         op(8, 1'b0, 16'd2, 16'd3, 32'h0000_0006, "post_reset", 1'b0);
      end

      for (int r = 0; r < 200; r++) begin
         int w;
         bit sm;
         logic [15:0] a, b;
         w  = (r % 2 == 0) ? 16 : 8;
         sm = 1'($urandom);
         a  = 16'($urandom);
         b  = 16'($urandom);
         if (w == 8) begin a[15:8] = 8'h0; b[15:8] = 8'h0; end
         op(w, sm, a, b, ref_mul(w, sm, a, b), "random", 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiplicador_param.md
# multiplicador_param

Parametrised sequential multiplier that generalises the fixed 8x8 start/done multiplier to WIDTH-bit operands, adds a signed two's-complement mode, and adds a busy output. It sits as a stand-alone arithmetic unit driven by a controller over a start/done handshake. The multiplier consumes one DIGIT-bit digit of the multiplier operand per cycle, accumulating shifted partial products. The result is held stable until the next accepted start.

## Interface
- WIDTH, 8: operand width in bits. Must satisfy WIDTH ≥ 4 and WIDTH % DIGIT == 0.
- DIGIT, 4: bits of entryB consumed per cycle. Number of digit cycles N = WIDTH/DIGIT.
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- start  in  1  request; accepted only in IDLE.
- signed_mode  in  1  1 = two's-complement operands/result, 0 = unsigned; sampled with start.
- entryA  in  WIDTH  multiplicand; sampled with start.
- entryB  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while an operation is in progress (CALC and FIN).
- done  out  1  one-cycle pulse when result becomes valid.
- result  out  2*WIDTH  product, held until next accepted start.

## Operation
- States are IDLE, CALC and FIN.
- IDLE, start=1:
  - Latch magA = |entryA| and magB = |entryB| when signed_mode=1, raw values otherwise.
  - Latch neg = signed_mode & (entryA[W-1] ^ entryB[W-1]).
  - Clear acc and digit counter i.
  - Go to CALC.
- CALC:
  - acc <= acc + ((magA * magB[i*DIGIT +: DIGIT]) << (i*DIGIT)); i <= i+1.
  - After digit N-1 is accumulated, go to FIN.
- FIN:
  - result <= neg ? -acc : acc (2*WIDTH-bit two's complement); done <= 1.
  - Next state is IDLE.
- Widths:
  - magA and magB are WIDTH bits unsigned. |−2^(W−1)| = 2^(W−1) fits in WIDTH bits, so no overflow.
  - Each partial product is WIDTH+DIGIT bits; acc is 2*WIDTH bits and never overflows.
- A zero product with neg=1 yields 0; negating 0 in two's complement is 0.
- start while busy=1 (CALC or FIN) is ignored. It is not queued and has no effect on the operation in flight.
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; acc, magA, magB, i, neg cleared.
  - Outputs: result=0, done=0, busy=0.
  - Mid-operation reset aborts with no done pulse.
- Inputs other than start are don't-care outside the start-acceptance cycle.

## Timing
- Start accepted at edge t0.
- busy=1 from t0 until the edge after done; the cycle count follows from the transitions below.
- CALC occupies edges t1..tN; the FIN transition is t(N+1).
- result is updated and done=1 after edge t(N+1). Latency is N+1 cycles; with defaults, 3.
- Return to IDLE is at edge t(N+2): done falls and busy falls.
- A new start presented in the cycle after done is accepted. Back-to-back throughput is one product per N+2 cycles.
- done is registered and never combinationally dependent on start.

## Structure
- Shared package multiplicador_pkg holds:
  - the state typedef (IDLE, CALC, FIN, 2-bit encoding);
  - a function or localparam for N = WIDTH/DIGIT and the counter width $clog2(N) (minimum 1).
- Sub-module digit_product: combinational unsigned WIDTH x DIGIT multiplier with a WIDTH+DIGIT output, parametrised by WIDTH and DIGIT. Instantiated once.
- The top level holds the FSM, the operand/sign registers, the accumulator and the output register.
- Elaboration-time check: fail if WIDTH % DIGIT != 0.

## Test plan
- Unsigned, WIDTH=8/DIGIT=4, A=200, B=150, start one cycle -> busy rises; done pulses exactly 3 cycles after start edge; result=0x7530. Result holds 0x7530 for 10 idle cycles.
- Unsigned extremes, WIDTH=8: 255*255 -> 0xFE01; 0*173 -> 0x0000. With signed_mode=1, −5*0 -> 0x0000.
- Signed, WIDTH=8:
  - −128*−128 (0x80,0x80) -> 0x4000;
  - −1*127 (0xFF,0x7F) -> 0xFF81;
  - 0x80 with signed_mode=0 times 2 -> 0x0100.
- Handshake abuse:
  - start=1 held for 6 cycles on 3*4 -> exactly one done per accepted start. The second start is accepted at the cycle after done.
  - Operands changed during CALC do not alter result 0x000C.
- Reset: reset_n=0 during CALC of 200*150 -> next cycle busy=0, done=0, result=0, no done pulse ever. A fresh 2*3 then yields 0x0006 with normal latency.
- Generalised width, WIDTH=16/DIGIT=4: 0xFFFF*0xFFFF unsigned -> 0xFFFE0001, latency 5. Signed 0x8000*0x7FFF -> 0xC0008000. Also 200 random signed and unsigned pairs checked against a reference model.
